// File: rtl/ssp_rx_dma_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ssp_rx_dma_ctrl_if
// Description : Signal bundle between the SSP Rx FIFO / register block, the
//               DMA controller and the Rx DMA request controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface ssp_rx_dma_ctrl_if;
    logic       RXDMAE;
    logic [3:0] RxFFillLevel;
    logic       RNE;
    logic       RxFRdPtrInc;
    logic       SSPRXDMACLR;
    logic       RTIC;
    logic       RTIM;
    logic       SSPRXDMASREQ;
    logic       SSPRXDMABREQ;
    logic       DmaRdErr;
    logic       RTRIS;
    logic       RTMIS;

    // Controller side
    modport slave (
        input  RXDMAE, RxFFillLevel, RNE, RxFRdPtrInc, SSPRXDMACLR, RTIC, RTIM,
        output SSPRXDMASREQ, SSPRXDMABREQ, DmaRdErr, RTRIS, RTMIS
    );

    // FIFO / register block / DMA side
    modport master (
        output RXDMAE, RxFFillLevel, RNE, RxFRdPtrInc, SSPRXDMACLR, RTIC, RTIM,
        input  SSPRXDMASREQ, SSPRXDMABREQ, DmaRdErr, RTRIS, RTMIS
    );
endinterface
`default_nettype wire

// File: rtl/ssp_rx_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ssp_rx_dma_ctrl
// Description : SSP receive-side DMA request generator (single/burst) with
//               over-read detection and receive-timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ssp_rx_dma_ctrl #(
    parameter int BURST_LEN   = 4,
    parameter int TIMEOUT_CYC = 32
) (
    input  wire logic         PCLK,
    input  wire logic         PRESETn,
    ssp_rx_dma_ctrl_if.slave  bus
);

    localparam logic [3:0] c_burst_len = 4'(BURST_LEN);
    localparam logic [7:0] c_timeout   = 8'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SREQ = 2'd1,
        ST_BREQ = 2'd2,
        ST_WCLR = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_burst_cnt;
    logic       r_sreq;
    logic       r_breq;
    logic       r_rd_err;
    logic       r_armed;
    logic [7:0] r_to_cnt;
    logic       r_to_fired;
    logic       r_rtris;

    logic       w_burst_ok;
    logic       w_to_clr;
    logic       w_to_set;

    assign w_burst_ok = (bus.RxFFillLevel >= c_burst_len);
    assign w_to_clr   = !bus.RNE || bus.RxFRdPtrInc || w_burst_ok;
    // One-shot set on the cycle after the counter has saturated, so a clear
    // from RTIC sticks while the counter stays parked at the limit.
    assign w_to_set   = (r_to_cnt == c_timeout) && !r_to_fired;

    // Blocks requests on the first edge after reset release.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_armed <= 1'b0;
        else          r_armed <= 1'b1;
    end

    // Request state machine with registered request outputs and burst counter.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= 4'd0;
            r_sreq      <= 1'b0;
            r_breq      <= 1'b0;
            r_rd_err    <= 1'b0;
        end else if (!bus.RXDMAE) begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= 4'd0;
            r_sreq      <= 1'b0;
            r_breq      <= 1'b0;
            r_rd_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_armed && w_burst_ok) begin
                        r_state     <= ST_BREQ;
                        r_burst_cnt <= c_burst_len;
                        r_sreq      <= 1'b1;
                        r_breq      <= 1'b1;
                    end else if (r_armed && bus.RNE) begin
                        r_state <= ST_SREQ;
                        r_sreq  <= 1'b1;
                        r_breq  <= 1'b0;
                    end
                end
                ST_SREQ: begin
                    if (bus.SSPRXDMACLR) begin
                        r_state <= ST_WCLR;
                        r_sreq  <= 1'b0;
                        r_breq  <= 1'b0;
                    end else if (w_burst_ok) begin
                        r_state     <= ST_BREQ;
                        r_burst_cnt <= c_burst_len;
                        r_breq      <= 1'b1;
                    end else if (!bus.RNE) begin
                        r_state <= ST_IDLE;
                        r_sreq  <= 1'b0;
                    end
                end
                ST_BREQ: begin
                    if (bus.RxFRdPtrInc) begin
                        if (r_burst_cnt != 4'd0) r_burst_cnt <= r_burst_cnt - 4'd1;
                        else                     r_rd_err    <= 1'b1;
                    end
                    if (bus.SSPRXDMACLR) begin
                        r_state <= ST_WCLR;
                        r_sreq  <= 1'b0;
                        r_breq  <= 1'b0;
                    end
                end
                ST_WCLR: begin
                    if (!bus.SSPRXDMACLR) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sreq  <= 1'b0;
                    r_breq  <= 1'b0;
                end
            endcase
        end
    end

    // Receive-timeout counter and raw status flag; independent of RXDMAE.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_to_cnt   <= 8'd0;
            r_to_fired <= 1'b0;
            r_rtris    <= 1'b0;
        end else begin
            if (w_to_clr) begin
                r_to_cnt <= 8'd0;
            end else if (r_to_cnt != c_timeout) begin
                r_to_cnt <= r_to_cnt + 8'd1;
            end

            if (w_to_clr)      r_to_fired <= 1'b0;
            else if (w_to_set) r_to_fired <= 1'b1;

            if (w_to_set)                            r_rtris <= 1'b1;
            else if (bus.RTIC || bus.RxFRdPtrInc)    r_rtris <= 1'b0;
        end
    end

    assign bus.SSPRXDMASREQ = r_sreq;
    assign bus.SSPRXDMABREQ = r_breq;
    assign bus.DmaRdErr     = r_rd_err;
    assign bus.RTRIS        = r_rtris;
    assign bus.RTMIS        = r_rtris & bus.RTIM;

endmodule
`default_nettype wire

// File: tb/tb_ssp_rx_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssp_rx_dma_ctrl
// Description : Directed self-checking bench for ssp_rx_dma_ctrl
//               (BURST_LEN=4, TIMEOUT_CYC=32). Observed vector is
//               {SREQ, BREQ, DmaRdErr, RTRIS, RTMIS}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssp_rx_dma_ctrl;

    logic PCLK;
    logic PRESETn;
    int   n_tests;
    int   n_fail;

    ssp_rx_dma_ctrl_if bus ();

    ssp_rx_dma_ctrl #(
        .BURST_LEN   (4),
        .TIMEOUT_CYC (32)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    function automatic logic [4:0] outs();
        return {bus.SSPRXDMASREQ, bus.SSPRXDMABREQ, bus.DmaRdErr, bus.RTRIS, bus.RTMIS};
    endfunction

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.RXDMAE       = 1'b0;
        bus.RxFFillLevel = 4'd0;
        bus.RNE          = 1'b0;
        bus.RxFRdPtrInc  = 1'b0;
        bus.SSPRXDMACLR  = 1'b0;
        bus.RTIC         = 1'b0;
        bus.RTIM         = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        idle_inputs();
        tick(); tick();
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL reset_state: got %b required %b", outs(), 5'b00000); end
        bus.RXDMAE = 1'b1; bus.RxFFillLevel = 4'd4; bus.RNE = 1'b1;
        tick();
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL reset_held: got %b required %b", outs(), 5'b00000); end
        PRESETn = 1'b1;
        tick();
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL reset_first_edge: got %b required %b", outs(), 5'b00000); end
        tick();
        n_tests++;
        if (outs() !== 5'b11000) begin n_fail++; $display("FAIL reset_second_edge: got %b required %b", outs(), 5'b11000); end
        idle_inputs();
        tick();
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL reset_cleanup: got %b required %b", outs(), 5'b00000); end
    endtask

    task automatic test_burst();
        bus.RXDMAE = 1'b1;
        tick();
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL burst_empty: got %b required %b", outs(), 5'b00000); end
        bus.RxFFillLevel = 4'd4; bus.RNE = 1'b1;
        tick();
        n_tests++;
        if (outs() !== 5'b11000) begin n_fail++; $display("FAIL burst_req: got %b required %b", outs(), 5'b11000); end
        bus.RxFRdPtrInc = 1'b1;
        bus.RxFFillLevel = 4'd3; tick();
        bus.RxFFillLevel = 4'd2; tick();
        bus.RxFFillLevel = 4'd1; tick();
        n_tests++;
        if (outs() !== 5'b11000) begin n_fail++; $display("FAIL burst_mid: got %b required %b", outs(), 5'b11000); end
        bus.RxFFillLevel = 4'd0; bus.RNE = 1'b0; bus.SSPRXDMACLR = 1'b1;
        tick();
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL burst_clr: got %b required %b", outs(), 5'b00000); end
        bus.RxFRdPtrInc = 1'b0;
        tick();
        bus.SSPRXDMACLR = 1'b0;
        tick(); tick();
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL burst_idle: got %b required %b", outs(), 5'b00000); end
    endtask

    task automatic test_single();
        bus.RXDMAE = 1'b1; bus.RxFFillLevel = 4'd1; bus.RNE = 1'b1;
        tick();
        n_tests++;
        if (outs() !== 5'b10000) begin n_fail++; $display("FAIL single_req: got %b required %b", outs(), 5'b10000); end
        bus.SSPRXDMACLR = 1'b1; bus.RxFRdPtrInc = 1'b1; bus.RxFFillLevel = 4'd0; bus.RNE = 1'b0;
        tick();
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL single_clr: got %b required %b", outs(), 5'b00000); end
        bus.SSPRXDMACLR = 1'b0; bus.RxFRdPtrInc = 1'b0;
        tick(); tick();
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL single_no_rereq: got %b required %b", outs(), 5'b00000); end
        idle_inputs();
        tick();
    endtask

    task automatic test_over_read();
        bus.RXDMAE = 1'b1; bus.RxFFillLevel = 4'd4; bus.RNE = 1'b1;
        tick();
        bus.RxFRdPtrInc = 1'b1;
        repeat (4) tick();
        n_tests++;
        if (outs() !== 5'b11000) begin n_fail++; $display("FAIL overread_4th: got %b required %b", outs(), 5'b11000); end
        tick();
        n_tests++;
        if (outs() !== 5'b11100) begin n_fail++; $display("FAIL overread_5th: got %b required %b", outs(), 5'b11100); end
        bus.RxFRdPtrInc = 1'b0; bus.RXDMAE = 1'b0;
        tick();
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL overread_disable: got %b required %b", outs(), 5'b00000); end
        idle_inputs();
        tick();
    endtask

    task automatic test_upgrade();
        bus.RXDMAE = 1'b1; bus.RxFFillLevel = 4'd1; bus.RNE = 1'b1;
        tick();
        n_tests++;
        if (outs() !== 5'b10000) begin n_fail++; $display("FAIL upgrade_sreq: got %b required %b", outs(), 5'b10000); end
        bus.RxFFillLevel = 4'd4;
        tick();
        n_tests++;
        if (outs() !== 5'b11000) begin n_fail++; $display("FAIL upgrade_breq: got %b required %b", outs(), 5'b11000); end
        tick();
        n_tests++;
        if (outs() !== 5'b11000) begin n_fail++; $display("FAIL upgrade_hold: got %b required %b", outs(), 5'b11000); end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        bus.RXDMAE = 1'b1; bus.RxFFillLevel = 4'd4; bus.RNE = 1'b1;
        tick();
        bus.SSPRXDMACLR = 1'b1;
        tick(); tick();
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL b2b_wclr_hold: got %b required %b", outs(), 5'b00000); end
        bus.SSPRXDMACLR = 1'b0;
        tick();
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL b2b_gap: got %b required %b", outs(), 5'b00000); end
        tick();
        n_tests++;
        if (outs() !== 5'b11000) begin n_fail++; $display("FAIL b2b_rereq: got %b required %b", outs(), 5'b11000); end
        idle_inputs();
        tick();
    endtask

    task automatic test_disable();
        bus.RXDMAE = 1'b1; bus.RxFFillLevel = 4'd4; bus.RNE = 1'b1;
        tick();
        bus.RXDMAE = 1'b0;
        tick();
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL disable_drop: got %b required %b", outs(), 5'b00000); end
        bus.RXDMAE = 1'b1; bus.RxFFillLevel = 4'd0; bus.RNE = 1'b0;
        tick(); tick();
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL disable_idle: got %b required %b", outs(), 5'b00000); end
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        idle_inputs();
        tick();
        bus.RxFFillLevel = 4'd2; bus.RNE = 1'b1;
        repeat (32) tick();
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL timeout_early: got %b required %b", outs(), 5'b00000); end
        tick();
        n_tests++;
        if (outs() !== 5'b00010) begin n_fail++; $display("FAIL timeout_set: got %b required %b", outs(), 5'b00010); end
        bus.RTIM = 1'b1;
        #1;
        n_tests++;
        if (outs() !== 5'b00011) begin n_fail++; $display("FAIL timeout_masked: got %b required %b", outs(), 5'b00011); end
        bus.RTIC = 1'b1;
        tick();
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL timeout_clear: got %b required %b", outs(), 5'b00000); end
        bus.RTIC = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL timeout_no_reset: got %b required %b", outs(), 5'b00000); end
    endtask

    task automatic test_async_reset();
        bus.RXDMAE = 1'b1; bus.RxFFillLevel = 4'd4; bus.RNE = 1'b1; bus.RTIM = 1'b1;
        tick();
        bus.RxFRdPtrInc = 1'b1;
        repeat (5) tick();
        bus.RxFRdPtrInc = 1'b0;
        n_tests++;
        if (outs() !== 5'b11100) begin n_fail++; $display("FAIL arst_pre: got %b required %b", outs(), 5'b11100); end
        #2;
        PRESETn = 1'b0;
        #1;
        n_tests++;
        if (outs() !== 5'b00000) begin n_fail++; $display("FAIL arst_async: got %b required %b", outs(), 5'b00000); end
        idle_inputs();
        tick();
        PRESETn = 1'b1;
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_burst();
        test_single();
        test_over_read();
        test_upgrade();
        test_back_to_back();
        test_disable();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
